mem_responder: RTL and testbench

- Synthesizable single-port memory target for the multicycle RV32I core's memory bus. It is the responder end of the bus: it accepts mem_read/mem_write requests and returns mem_rdata/mem_resp.
- It applies per-byte write enables and answers each accepted request after a fixed, configurable latency.
- Used as on-chip RAM and as the bench memory for core bring-up, replacing the behavioural magic memory.

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory bus between the RV32I core (initiator) and a memory target (responder).
// The initiator holds mem_read/mem_write until the one-cycle mem_resp pulse.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp, mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word RAM answering core memory requests after a fixed LATENCY.
// Optional MEM_RANGE_CHECK_EN flags out-of-range addresses on mem_err instead of aliasing.
//
// state  | meaning
// IDLE   | waiting for a request; request inputs sampled only here
// WAIT   | latency down-counter running
// RESP   | mem_resp pulse; pending write commits on the edge ending this cycle
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  is_wr_q, is_wr_d;
    logic                  oor_q, oor_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  enter_resp;

    logic [31:0]           mem_q [DEPTH];

    logic                  req;
    logic                  req_oor;
    logic [ADDR_WIDTH-1:0] req_idx;

    assign req     = bus.mem_read | bus.mem_write;
    assign req_idx = bus.mem_address[ADDR_WIDTH+1:2];

`ifdef MEM_RANGE_CHECK_EN
    logic unused_addr;
    assign req_oor     = |bus.mem_address[31:ADDR_WIDTH+2];
    assign unused_addr = ^bus.mem_address[1:0];
`else
    logic unused_addr;
    assign req_oor     = 1'b0;
    assign unused_addr = ^{bus.mem_address[31:ADDR_WIDTH+2], bus.mem_address[1:0]};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_wr_d    = is_wr_q;
        oor_d      = oor_q;
        rdata_d    = rdata_q;
        resp_d     = 1'b0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    is_wr_d = bus.mem_write;
                    oor_d   = req_oor;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // idx_d is the live request index on IDLE->RESP and the latched one from WAIT
        if (enter_resp) begin
            resp_d = 1'b1;
            err_d  = oor_d;
            if (!is_wr_d) begin
                rdata_d = oor_d ? 32'h0 : mem_q[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            is_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            rdata_q <= 32'h0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            is_wr_q <= is_wr_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // Storage is never reset; a reset in RESP drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && is_wr_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_resp  = resp_q;
    assign bus.mem_err   = err_q;

    a_no_read_and_write: assert property (
        @(posedge clk) disable iff (rst) !(bus.mem_read && bus.mem_write)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one LATENCY=2 instance for functional
// scenarios and one LATENCY=1 instance for back-to-back throughput.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_responder_if if2 ();
    mem_responder_if if1 ();

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // Reference memory for randomized traffic, keyed by word index.
    logic [31:0] model [int];
    logic [31:0] last_rd;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Issue one request on the LATENCY=2 instance, holding it until mem_resp.
    // lat is the number of cycles from acceptance to the response (-1 on timeout).
    task automatic txn2(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output int lat);
        lat = -1;
        rd  = 32'h0;
        err = 1'b0;
        if2.mem_read        = !wr;
        if2.mem_write       = wr;
        if2.mem_address     = addr;
        if2.mem_wdata       = wd;
        if2.mem_byte_enable = be;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (if2.mem_resp) begin
                lat = i;
                rd  = if2.mem_rdata;
                err = if2.mem_err;
                break;
            end
        end
        if2.mem_read  = 1'b0;
        if2.mem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if2.mem_resp !== 1'b0) begin
            failures++;
            $display("FAIL resp_single_pulse: got %b expected 0", if2.mem_resp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (if2.mem_resp !== 1'b0 || if2.mem_err !== 1'b0 || if2.mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got resp=%b err=%b rdata=%h expected 0 0 00000000",
                     if2.mem_resp, if2.mem_err, if2.mem_rdata);
        end
        checks++;
        if (if1.mem_resp !== 1'b0 || if1.mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs_lat1: got resp=%b rdata=%h expected 0 00000000",
                     if1.mem_resp, if1.mem_rdata);
        end
    endtask

    task automatic test_full_word();
        logic [31:0] rd; logic err; int lat;
        txn2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL full_write_latency: got %0d expected 2", lat); end
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL full_read_latency: got %0d expected 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL full_read_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; logic err; int lat;
        txn2(1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, err, lat);
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hDEADABEF) begin failures++; $display("FAIL byte_write_data: got %h expected deadabef", rd); end
    endtask

    task automatic test_halfword_and_no_lanes();
        logic [31:0] rd; logic err; int lat;
        txn2(1'b1, 32'h12, 32'h12340000, 4'b1100, rd, err, lat);
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h1234ABEF) begin failures++; $display("FAIL halfword_data: got %h expected 1234abef", rd); end
        txn2(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, err, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL no_lane_write_resp: got latency %0d expected 2", lat); end
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h1234ABEF) begin failures++; $display("FAIL no_lane_write_data: got %h expected 1234abef", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic err; int lat; int pulses;
        if2.mem_write       = 1'b1;
        if2.mem_read        = 1'b0;
        if2.mem_address     = 32'h10;
        if2.mem_wdata       = 32'hFFFFFFFF;
        if2.mem_byte_enable = 4'hF;
        @(posedge clk); #1;
        rst           = 1'b1;
        if2.mem_write = 1'b0;
        pulses = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (if2.mem_rdata !== 32'h0) begin failures++; $display("FAIL abort_rdata_reset: got %h expected 00000000", if2.mem_rdata); end
        for (int i = 0; i < 5; i++) begin
            if (if2.mem_resp) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL abort_no_resp: got %0d pulses expected 0", pulses); end
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h1234ABEF) begin failures++; $display("FAIL abort_no_commit: got %h expected 1234abef", rd); end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic err; int lat;
        txn2(1'b1, 32'h1010, 32'h55555555, 4'hF, rd, err, lat);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL range_write_latency: got %0d expected 2", lat); end
`ifdef MEM_RANGE_CHECK_EN
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL range_write_err: got %b expected 1", err); end
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h1234ABEF || err !== 1'b0) begin
            failures++; $display("FAIL range_no_alias: got %h err=%b expected 1234abef err=0", rd, err);
        end
        txn2(1'b0, 32'h1010, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1 || lat != 2) begin
            failures++; $display("FAIL range_read: got %h err=%b lat=%0d expected 00000000 err=1 lat=2", rd, err, lat);
        end
        checks++;
        if (if2.mem_err !== 1'b0) begin failures++; $display("FAIL range_err_idle: got %b expected 0", if2.mem_err); end
`else
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL alias_write_err: got %b expected 0", err); end
        txn2(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h55555555) begin failures++; $display("FAIL alias_read: got %h expected 55555555", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, addr; logic err; int lat; int idx; logic [3:0] be; bit wr;
        for (int i = 32; i < 48; i++) begin
            wd = $urandom;
            txn2(1'b1, 32'(i * 4), wd, 4'hF, rd, err, lat);
            model[i] = wd;
        end
        last_rd = if2.mem_rdata;
        for (int n = 0; n < 40; n++) begin
            idx  = int'($urandom_range(32, 47));
            addr = 32'(idx * 4) | 32'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            txn2(wr, addr, wd, be, rd, err, lat);
            checks++;
            if (lat != 2) begin failures++; $display("FAIL rand_latency: op %0d got %0d expected 2", n, lat); end
            if (wr) begin
                model[idx] = (model[idx] & ~lane_mask(be)) | (wd & lane_mask(be));
                checks++;
                if (rd !== last_rd) begin failures++; $display("FAIL rand_rdata_hold: op %0d got %h expected %h", n, rd, last_rd); end
            end else begin
                checks++;
                if (rd !== model[idx]) begin failures++; $display("FAIL rand_read: op %0d idx %0d got %h expected %h", n, idx, rd, model[idx]); end
                last_rd = model[idx];
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          op_wr   [4];
        logic [31:0] op_addr [4];
        logic [31:0] op_wd   [4];
        logic [31:0] exp_rd  [4];
        int k, prev, cyc;
        op_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
        op_addr = '{32'h40, 32'h40, 32'h44, 32'h44};
        op_wd   = '{32'hA5A50F0F, 32'h0, 32'h3C3C1234, 32'h0};
        exp_rd  = '{32'h0, 32'hA5A50F0F, 32'hA5A50F0F, 32'h3C3C1234};
        k = 0; prev = -1; cyc = 0;
        if1.mem_write = op_wr[0]; if1.mem_read = !op_wr[0];
        if1.mem_address = op_addr[0]; if1.mem_wdata = op_wd[0]; if1.mem_byte_enable = 4'hF;
        while (k < 4 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (if1.mem_resp) begin
                checks++;
                if (cyc - prev != 2) begin failures++; $display("FAIL b2b_interval: resp %0d got %0d cycles expected 2", k, cyc - prev); end
                checks++;
                if (if1.mem_rdata !== exp_rd[k]) begin failures++; $display("FAIL b2b_rdata: resp %0d got %h expected %h", k, if1.mem_rdata, exp_rd[k]); end
                prev = cyc;
                k++;
                if (k < 4) begin
                    if1.mem_write = op_wr[k]; if1.mem_read = !op_wr[k];
                    if1.mem_address = op_addr[k]; if1.mem_wdata = op_wd[k];
                end else begin
                    if1.mem_write = 1'b0; if1.mem_read = 1'b0;
                end
            end
        end
        checks++;
        if (k != 4) begin failures++; $display("FAIL b2b_timeout: got %0d responses expected 4", k); end
    endtask

    initial begin
        rst = 1'b1;
        if2.mem_read = 1'b0; if2.mem_write = 1'b0; if2.mem_address = 32'h0;
        if2.mem_wdata = 32'h0; if2.mem_byte_enable = 4'h0;
        if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_address = 32'h0;
        if1.mem_wdata = 32'h0; if1.mem_byte_enable = 4'h0;
        test_reset();
        test_full_word();
        test_byte_write();
        test_halfword_and_no_lanes();
        test_reset_abort();
        test_range();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
